// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pc_sequencer
// Brief  : Program-counter sequencer for the 8-bit core. Drives the
//          instruction-ROM address, chooses sequential or taken flow from the
//          ALU branch flag and the branch LUT target, and owns the start/done
//          handshake with the test harness.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1     system clock, rising edge
//   rst_n        in   1     asynchronous active-low reset
//   start        in   1     begin/restart execution (level, sampled per cycle)
//   stall        in   1     freeze PC and state this cycle (RUN only)
//   halt_instr   in   1     current instruction is HALT
//   branch_en    in   1     current instruction is a conditional branch
//   branch_flag  in   1     ALU branch flag for the current instruction
//   lut_target   in   PC_W  branch target for the current instruction
//   pc           out  PC_W  instruction-ROM address (registered)
//   running      out  1     high while in RUN
//   done         out  1     high while in DONE
//   fault        out  1     DONE was reached by overrun or an illegal target
//   retired      out  16    (PC_RETIRE_CNT_EN only) unstalled RUN cycle count
// Configuration
//   PC_RETIRE_CNT_EN : when defined, adds the saturating retired counter.
// ============================================================================
module pc_sequencer #(
  parameter int PC_W       = 12,
  parameter int PROG_DEPTH = 4096,
  parameter int START_ADDR = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  input  logic            halt_instr,
  input  logic            branch_en,
  input  logic            branch_flag,
  input  logic [PC_W-1:0] lut_target,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            done,
  output logic            fault
`ifdef PC_RETIRE_CNT_EN
  ,
  output logic [15:0]     retired
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] LAST_PC  = PC_W'(PROG_DEPTH - 1);
  // One extra bit so a full 2**PC_W depth is still representable.
  localparam logic [PC_W:0]   TARGET_LIMIT = (PC_W+1)'(PROG_DEPTH);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;

  logic            w_target_ok;
  logic            w_at_last;
  logic            w_taken;

  assign w_target_ok = ({1'b0, lut_target} < TARGET_LIMIT);
  assign w_at_last   = (pc_q == LAST_PC);
  assign w_taken     = branch_en & branch_flag;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          fault_d = 1'b0;
        end
      end
      S_RUN: begin
        // Priority: stall > halt > taken branch > increment.
        if (!stall) begin
          if (halt_instr) begin
            state_d = S_DONE;
            fault_d = 1'b0;
          end else if (w_taken) begin
            if (w_target_ok) begin
              pc_d = lut_target;
            end else begin
              state_d = S_DONE;
              fault_d = 1'b1;
            end
          end else if (w_at_last) begin
            // Overrun is detected before incrementing so pc never wraps.
            state_d = S_DONE;
            fault_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          fault_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = START_PC;
        fault_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign pc      = pc_q;
  assign running = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign fault   = fault_q;

`ifdef PC_RETIRE_CNT_EN
  logic [15:0] retired_q, retired_d;
  logic        w_accept_start;

  // A start is only accepted outside RUN; it restarts the count.
  assign w_accept_start = start & (state_q != S_RUN);

  always_comb begin
    retired_d = retired_q;
    if (w_accept_start) begin
      retired_d = 16'h0000;
    end else if ((state_q == S_RUN) && !stall && (retired_q != 16'hFFFF)) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 16'h0000;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`endif

endmodule

`default_nettype wire
